// File: rtl/magnitude_sched.sv
// Two-requester round-robin scheduler feeding a sequential integer square root.
// Produces floor(sqrt(dx^2 + dy^2)) with a fixed 11-cycle accept-to-result latency.
module magnitude_sched #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_dx,
  input  logic [7:0] req0_dy,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_dx,
  input  logic [7:0] req1_dy,
  output logic       req1_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_mag,
  output logic       out_id,
  output logic       busy
);

  localparam logic PTR_RST   = (RR_INIT != 0);
  localparam int   NSTEPS    = 9;
  localparam int   MW        = 18;

  typedef enum logic [1:0] {IDLE, SQUARE, ITER, DONE} state_t;

  typedef struct packed {
    logic       id;
    logic [7:0] dx;
    logic [7:0] dy;
  } req_t;

  state_t          state, nstate;
  logic            ptr;
  logic            grant1;
  logic            hs;
  req_t            req_q, req_sel;
  logic [MW-1:0]   m_q, res_q, bit_q;
  logic [MW-1:0]   trial, m_nx, res_nx;
  logic            ge;
  logic [16:0]     sumsq;
  logic [3:0]      cnt_q;
  logic            last_step;
  logic            unused_res;

  // Tie goes to the pointer; a lone valid always wins.
  assign grant1    = req1_valid && (!req0_valid || ptr);
  assign hs        = req0_ready || req1_ready;
  assign last_step = (cnt_q == 4'(NSTEPS - 1));

  always_comb begin
    req_sel = '{id: 1'b0, dx: req0_dx, dy: req0_dy};
    if (req1_ready) req_sel = '{id: 1'b1, dx: req1_dx, dy: req1_dy};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (hs)        nstate = SQUARE;
      SQUARE:                 nstate = ITER;
      ITER:    if (last_step) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // FSM: outputs; readies are gated by rst_n so nothing is granted while held in reset
  always_comb begin
    busy       = (state != IDLE);
    out_valid  = (state == DONE);
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant1;
    req1_ready = rst_n && (state == IDLE) && grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= PTR_RST;
    else if (hs) ptr <= req0_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     req_q <= '0;
    else if (state == IDLE && hs)   req_q <= req_sel;
  end

  assign sumsq = 17'(req_q.dx) * 17'(req_q.dx) + 17'(req_q.dy) * 17'(req_q.dy);

  // One digit-by-digit square root step; bit walks 2^16 down to 2^0 over 9 steps.
  always_comb begin
    trial  = res_q + bit_q;
    ge     = (m_q >= trial);
    m_nx   = ge ? (m_q - trial) : m_q;
    res_nx = ge ? ((res_q >> 1) + bit_q) : (res_q >> 1);
  end

  assign unused_res = ^res_nx[MW-1:9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      res_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
    end else if (state == SQUARE) begin
      m_q   <= MW'(sumsq);
      res_q <= '0;
      bit_q <= MW'(1) << 16;
      cnt_q <= '0;
    end else if (state == ITER) begin
      m_q   <= m_nx;
      res_q <= res_nx;
      bit_q <= bit_q >> 2;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Result registers only load on DONE entry, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mag <= '0;
      out_id  <= 1'b0;
    end else if (state == ITER && last_step) begin
      out_mag <= res_nx[8:0];
      out_id  <= req_q.id;
    end
  end

endmodule
